// File: rtl/phase_interval_meter_if.sv
// Result channel between the phase interval meter and its consumer.
// Ports (by modport):
//   master : drives meas_data, meas_lead, meas_timeout, meas_valid; samples meas_ready
//   slave  : samples the result fields and meas_valid; drives meas_ready
interface phase_interval_meter_if #(
   parameter int unsigned CNT_W = 16
);

   logic [CNT_W-1:0] meas_data;
   logic             meas_lead;
   logic             meas_timeout;
   logic             meas_valid;
   logic             meas_ready;

   modport master (
      output meas_data,
      output meas_lead,
      output meas_timeout,
      output meas_valid,
      input  meas_ready
   );

   modport slave (
      input  meas_data,
      input  meas_lead,
      input  meas_timeout,
      input  meas_valid,
      output meas_ready
   );

endinterface

// File: rtl/phase_interval_meter.sv
// Measures the number of clk cycles between a rising edge on ref_in and the
// next rising edge on sig_in (either may come first) and hands each result to
// downstream logic over a valid/ready channel.
// Ports:
//   clk      : measurement clock
//   rst_n    : asynchronous active-low reset
//   enable   : level-sensitive arm; dropping it mid-measurement aborts it
//   ref_in   : asynchronous reference input
//   sig_in   : asynchronous signal under test
//   busy     : high while counting or while a result waits for handshake
//   meas     : result channel (data, lead, timeout, valid / ready)
module phase_interval_meter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 65535
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   ref_in,
   input  logic                   sig_in,
   output logic                   busy,
   phase_interval_meter_if.master meas
);

   localparam longint unsigned CNT_MAX   = (64'(1) << CNT_W) - 64'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   // Parameter legality, caught at elaboration so the counter can never wrap.
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("phase_interval_meter: SYNC_STAGES must be at least 2");
   end
   if ((TIMEOUT < 1) || (64'(TIMEOUT) > CNT_MAX)) begin : g_bad_timeout
      $error("phase_interval_meter: TIMEOUT must be in 1..2^CNT_W-1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Synchronizers and rising-edge detectors; both paths have equal depth
   // so the measured interval is preserved.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] ref_sync_q;
   logic [SYNC_STAGES-1:0] sig_sync_q;
   logic                   ref_prev_q;
   logic                   sig_prev_q;
   logic                   ref_e;
   logic                   sig_e;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_sync_q <= '0;
         sig_sync_q <= '0;
         ref_prev_q <= 1'b0;
         sig_prev_q <= 1'b0;
      end else begin
         ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], ref_in};
         sig_sync_q <= {sig_sync_q[SYNC_STAGES-2:0], sig_in};
         ref_prev_q <= ref_sync_q[SYNC_STAGES-1];
         sig_prev_q <= sig_sync_q[SYNC_STAGES-1];
      end
   end

   assign ref_e = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
   assign sig_e = sig_sync_q[SYNC_STAGES-1] & ~sig_prev_q;

   // ------------------------------------------------------------------
   // Measurement FSM: state and all output registers.
   // ------------------------------------------------------------------
   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             lead_q;       // which edge opened the running measurement
   logic             lead_d;
   logic             close_e;
   logic [CNT_W-1:0] data_q;
   logic [CNT_W-1:0] data_d;
   logic             res_lead_q;
   logic             res_lead_d;
   logic             timeout_q;
   logic             timeout_d;
   logic             valid_q;
   logic             valid_d;
   logic             busy_q;
   logic             busy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         lead_q     <= 1'b0;
         data_q     <= '0;
         res_lead_q <= 1'b0;
         timeout_q  <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lead_q     <= lead_d;
         data_q     <= data_d;
         res_lead_q <= res_lead_d;
         timeout_q  <= timeout_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
      end
   end

   // The counter holds cycles-since-opening minus one, so cnt+1 is the interval.
   assign cnt_inc = cnt_q + CNT_W'(1);
   // Closing edge is the opposite input to the one that opened the measurement.
   assign close_e = lead_q ? ref_e : sig_e;

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lead_d     = lead_q;
      data_d     = data_q;
      res_lead_d = res_lead_q;
      timeout_d  = timeout_q;
      valid_d    = valid_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (enable) begin
               if (ref_e && sig_e) begin
                  // Coincident edges: zero interval, reported as ref-first.
                  state_d    = S_DONE;
                  data_d     = '0;
                  res_lead_d = 1'b0;
                  timeout_d  = 1'b0;
                  valid_d    = 1'b1;
               end else if (ref_e) begin
                  state_d = S_COUNT;
                  lead_d  = 1'b0;
               end else if (sig_e) begin
                  state_d = S_COUNT;
                  lead_d  = 1'b1;
               end
            end
         end

         S_COUNT: begin
            cnt_d = cnt_inc;
            if (!enable) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (close_e) begin
               // Closing edge wins over a coincident repeat of the opening edge
               // and over a coincident timeout.
               state_d    = S_DONE;
               data_d     = cnt_inc;
               res_lead_d = lead_q;
               timeout_d  = 1'b0;
               valid_d    = 1'b1;
            end else if (cnt_inc == TIMEOUT_C) begin
               state_d    = S_DONE;
               data_d     = TIMEOUT_C;
               res_lead_d = lead_q;
               timeout_d  = 1'b1;
               valid_d    = 1'b1;
            end
         end

         S_DONE: begin
            // Edges and enable are ignored here; the result is held until taken.
            if (valid_q && meas.meas_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign meas.meas_data    = data_q;
   assign meas.meas_lead    = res_lead_q;
   assign meas.meas_timeout = timeout_q;
   assign meas.meas_valid   = valid_q;
   assign busy              = busy_q;

endmodule
